// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for the 8-entry FIFO.
// Drives the dual-address FIFO memory's addresses and enables.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [ADDR_WIDTH-1:0] write_ptr,
  output logic [ADDR_WIDTH-1:0] read_ptr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  data_valid,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);

  logic push_acc;
  logic pop_acc;
  logic rejected;

  // Flags decode registered count only; acceptance from flags.
  always_comb begin
    fifo_full    = (fifo_count == DEPTH_C);
    fifo_empty   = (fifo_count == '0);
    almost_full  = (fifo_count >= umbral_alto);
    almost_empty = (fifo_count <= umbral_bajo);
    pop_acc      = pop & ~fifo_empty;
    push_acc     = push & (~fifo_full | pop_acc);
    rejected     = (push & ~push_acc) | (pop & ~pop_acc);
    write_enable = push_acc;
    read_enable  = pop_acc;
  end

  // Pointer, occupancy, read-valid and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_ptr  <= '0;
      read_ptr   <= '0;
      fifo_count <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (push_acc)
        write_ptr <= write_ptr + PTR_ONE;
      if (pop_acc)
        read_ptr <= read_ptr + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      data_valid <= pop_acc;
      error      <= rejected;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural memory
// driven by the controller's pointers and enables.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic [2:0] write_ptr;
  logic [2:0] read_ptr;
  logic       write_enable;
  logic       read_enable;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       data_valid;
  logic       error;

  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] mem [8];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];
  int         m_cnt;
  logic [2:0] m_wp;
  logic [2:0] m_rp;

  fifo_ctrl #(.ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .write_ptr    (write_ptr),
    .read_ptr     (read_ptr),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Memory reads the old word before any same-edge write.
  always_ff @(posedge clk) begin
    if (write_enable) mem[write_ptr] <= din;
    if (read_enable)  dout <= mem[read_ptr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("wptr", 32'(write_ptr), 32'(m_wp));
    check("rptr", 32'(read_ptr), 32'(m_rp));
    check("count", 32'(fifo_count), 32'(m_cnt));
    check("full", 32'(fifo_full), 32'(m_cnt == 8));
    check("empty", 32'(fifo_empty), 32'(m_cnt == 0));
    check("afull", 32'(almost_full),
          32'(m_cnt >= int'(umbral_alto)));
    check("aempty", 32'(almost_empty),
          32'(m_cnt <= int'(umbral_bajo)));
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_wp  = '0;
    m_rp  = '0;
    exp_q.delete();
  endtask

  // One clock of stimulus; called at posedge+1.
  task automatic step(input bit p, input bit q,
                      input logic [7:0] d);
    bit pa;
    bit wa;
    logic [7:0] w;
    push = p;
    pop  = q;
    din  = d;
    #1;
    pa = q && (m_cnt != 0);
    wa = p && ((m_cnt != 8) || pa);
    check("rd_en", 32'(read_enable), 32'(pa));
    check("wr_en", 32'(write_enable), 32'(wa));
    @(posedge clk);
    #1;
    if (wa) begin
      exp_q.push_back(d);
      m_wp = m_wp + 3'd1;
    end
    if (pa) m_rp = m_rp + 3'd1;
    m_cnt = m_cnt + int'(wa) - int'(pa);
    check("err", 32'(error),
          32'((p && !wa) || (q && !pa)));
    check("dvalid", 32'(data_valid), 32'(pa));
    if (data_valid) begin
      if (exp_q.size() == 0)
        check("data_q", 32'(1), 32'(0));
      else begin
        w = exp_q.pop_front();
        check("data", 32'(dout), 32'(w));
      end
    end
    check_state();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    umbral_alto = 4'd0;
    umbral_bajo = 4'd1;
    model_reset();
    #12;
    check("rst_afull0", 32'(almost_full), 32'(1));
    check_state();
    check("rst_dv", 32'(data_valid), 32'(0));
    check("rst_err", 32'(error), 32'(0));
    umbral_alto = 4'd6;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Count to 5 with a pop in flight, then reset.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 8'h10 + 8'(i));
    step(1'b0, 1'b1, 8'h00);
    check("pre_rst_cnt", 32'(fifo_count), 32'(5));
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_dv", 32'(data_valid), 32'(0));
    check("mid_rst_err", 32'(error), 32'(0));
    check_state();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill with A0..A7, then overflow.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 8'hA0 + 8'(i));
    step(1'b1, 1'b0, 8'hEE);
    check("ovf_wptr", 32'(write_ptr), 32'(0));
    step(1'b0, 1'b0, 8'h00);

    // Drain in order, then underflow.
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 8'h00);

    // Steady push&pop at count 3, pointers wrap.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 8'h40 + 8'(i));
    check("pp_cnt", 32'(fifo_count), 32'(3));

    // Drain, then push&pop on empty.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h77);
    check("pp_empty_cnt", 32'(fifo_count), 32'(1));

    // Fill, then push&pop on full.
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, 8'h80 + 8'(i));
    step(1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b0, 8'h00);
    check("pp_full_cnt", 32'(fifo_count), 32'(8));

    // Live threshold change re-decodes flags only.
    umbral_alto = 4'd8;
    #1;
    check("thr_afull8", 32'(almost_full), 32'(1));
    umbral_alto = 4'd9;
    #1;
    check("thr_afull9", 32'(almost_full), 32'(0));
    umbral_alto = 4'd6;

    // Almost-empty with umbral_bajo=2 from count 4.
    umbral_bajo = 4'd2;
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'h00);
    check("ae_cnt4", 32'(almost_empty), 32'(0));
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'h00);
    check("ae_cnt0", 32'(almost_empty), 32'(1));

    // Random mix.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           8'($urandom));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
